// File: rtl/mul_acc_pkg.sv
// Shared types and helpers for the mul_acc_uns product accumulator.
package mul_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mul_acc_state_e;

  // Counter must be able to hold maxCount itself, not just maxCount-1.
  function automatic int count_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  function automatic bit params_ok(input int width_p, input int width_acc, input int max_count);
    return (width_acc >= width_p) && (max_count >= 1);
  endfunction

endpackage

// File: rtl/mul_acc_uns_add.sv
// Parallel-prefix adder: speed 0 ripple, 1 Brent-Kung, 2 Sklansky.
module Add #(
  parameter int width = 8,
  parameter int speed = 1
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] s
);

  localparam int L = (width > 1) ? $clog2(width) : 1;

  always_comb begin : prefix
    logic [width-1:0] g;
    logic [width-1:0] p;
    logic [width-1:0] gp;
    logic [width-1:0] pp;
    int j;
    g  = a & b;
    p  = a ^ b;
    gp = g;
    pp = p;
    j  = 0;
    if (speed == 0) begin
      for (int i = 1; i < width; i++) begin
        gp[i] = gp[i] | (pp[i] & gp[i-1]);
        pp[i] = pp[i] & pp[i-1];
      end
    end else if (speed == 1) begin
      for (int l = 0; l < L; l++) begin
        for (int i = (2 << l) - 1; i < width; i += (2 << l)) begin
          j     = i - (1 << l);
          gp[i] = gp[i] | (pp[i] & gp[j]);
          pp[i] = pp[i] & pp[j];
        end
      end
      for (int l = L - 2; l >= 0; l--) begin
        for (int i = (3 << l) - 1; i < width; i += (2 << l)) begin
          j     = i - (1 << l);
          gp[i] = gp[i] | (pp[i] & gp[j]);
          pp[i] = pp[i] & pp[j];
        end
      end
    end else begin
      // Node j never has bit l set, so it is not rewritten within its own level.
      for (int l = 0; l < L; l++) begin
        for (int i = 0; i < width; i++) begin
          if (((i >> l) & 1) == 1) begin
            j     = ((i >> l) << l) - 1;
            gp[i] = gp[i] | (pp[i] & gp[j]);
            pp[i] = pp[i] & pp[j];
          end
        end
      end
    end
    s = p ^ {gp[width-2:0], 1'b0};
  end

endmodule

// File: rtl/mul_acc_uns.sv
// Streaming unsigned product accumulator with group close on last or count.
// Define MUL_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module mul_acc_uns
  import mul_acc_pkg::*;
#(
  parameter int widthP   = 32,
  parameter int widthAcc = 40,
  parameter int maxCount = 256,
  parameter int speed    = 1,
  localparam int CW      = count_width(maxCount)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                p_valid_i,
  output logic                p_ready_o,
  input  logic [widthP-1:0]   p_i,
  input  logic                p_last_i,
  output logic                sum_valid_o,
  input  logic                sum_ready_i,
  output logic [widthAcc-1:0] sum_o,
  output logic [CW-1:0]       count_o,
  output logic                ovf_o,
  output mul_acc_state_e      state_o
);

  if (!params_ok(widthP, widthAcc, maxCount)) begin : g_bad_params
    $error("mul_acc_uns: need widthAcc >= widthP and maxCount >= 1");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and p_ready_o never looks at p_valid_i.
  mul_acc_state_e      state_q, state_d;
  logic [widthAcc-1:0] acc_q, acc_d;
  logic [CW-1:0]       count_q, count_d, count_inc;
  logic                ovf_q, ovf_d;
  logic [widthAcc:0]   add_a, add_b, add_s;
  logic                carry, close;

  assign add_a = {1'b0, acc_q};
  assign add_b = (widthAcc + 1)'(p_i);

  Add #(.width(widthAcc + 1), .speed(speed)) u_add (
    .a (add_a),
    .b (add_b),
    .s (add_s)
  );

  assign carry     = add_s[widthAcc];
  assign count_inc = count_q + CW'(1);
  assign close     = p_last_i | (count_inc == CW'(maxCount));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    p_ready_o = 1'b0;
    case (state_q)
      ACCUM: begin
        p_ready_o = ~clear_i;
        if (clear_i) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (p_valid_i) begin
`ifdef MUL_ACC_SAT_EN
          acc_d = carry ? '1 : add_s[widthAcc-1:0];
`else
          acc_d = add_s[widthAcc-1:0];
`endif
          count_d = count_inc;
          ovf_d   = ovf_q | carry;
          if (close) state_d = HOLD;
        end
      end
      HOLD: begin
        if (sum_ready_i) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum_valid_o = (state_q == HOLD);
  assign sum_o       = acc_q;
  assign count_o     = count_q;
  assign ovf_o       = ovf_q;
  assign state_o     = state_q;

endmodule
